tap_classifier: RTL and testbench

- Consumes the single-cycle, already-debounced press pulse from the button front end (sync + debounce + edge detect).
- Groups consecutive presses that fall inside a timing window into one gesture: single, double or triple tap.
- Emits one registered, one-cycle event per gesture to the control FSM.
- Lets one physical button drive several commands without extra pins.

---
 rtl/tap_classifier.sv | 106 ++++++++++
 tb/tb_tap_classifier.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tap_classifier.sv
// Tap classifier: groups debounced press pulses that fall inside a timing
// window into single, double or triple tap gestures and reports each
// completed gesture as a registered one-cycle event.
module tap_classifier #(
   parameter int WINDOW_CYCLES = 30_000_000,
   parameter int TMR_W         = 25
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_pulse,
   input  logic       clear,
   output logic       evt_valid,
   output logic [1:0] evt_taps,
   output logic       single_tap,
   output logic       double_tap,
   output logic       triple_tap,
   output logic       busy
);

   // The gap timer stops at this value; reaching it closes the gesture.
   localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(WINDOW_CYCLES - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   state_t           state, state_next;
   logic [1:0]       taps, taps_next;
   logic [TMR_W-1:0] timer, timer_next;
   logic             evt_next;
   logic [1:0]       evt_taps_next;

   // Next-state and event decision; the pulse outranks the timeout, clear outranks both.
   always_comb begin
      state_next    = state;
      taps_next     = taps;
      timer_next    = timer;
      evt_next      = 1'b0;
      evt_taps_next = 2'd0;
      unique case (state)
         IDLE: begin
            if (btn_pulse) begin
               state_next = COUNT;
               taps_next  = 2'd1;
               timer_next = '0;
            end
         end
         COUNT: begin
            if (clear) begin
               state_next = IDLE;
               taps_next  = 2'd0;
               timer_next = '0;
            end else if (btn_pulse && taps == 2'd2) begin
               evt_next      = 1'b1;
               evt_taps_next = 2'd3;
               state_next    = IDLE;
               taps_next     = 2'd0;
               timer_next    = '0;
            end else if (btn_pulse) begin
               taps_next  = taps + 2'd1;
               timer_next = '0;
            end else if (timer == TIMER_LAST) begin
               evt_next      = 1'b1;
               evt_taps_next = taps;
               state_next    = IDLE;
               taps_next     = 2'd0;
               timer_next    = '0;
            end else begin
               timer_next = timer + TMR_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
            taps_next  = 2'd0;
            timer_next = '0;
         end
      endcase
   end

   // State register plus registered event outputs, all cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         taps       <= 2'd0;
         timer      <= '0;
         evt_valid  <= 1'b0;
         evt_taps   <= 2'd0;
         single_tap <= 1'b0;
         double_tap <= 1'b0;
         triple_tap <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_next;
         taps       <= taps_next;
         timer      <= timer_next;
         evt_valid  <= evt_next;
         evt_taps   <= evt_taps_next;
         single_tap <= evt_next && (evt_taps_next == 2'd1);
         double_tap <= evt_next && (evt_taps_next == 2'd2);
         triple_tap <= evt_next && (evt_taps_next == 2'd3);
         busy       <= (state_next == COUNT);
      end
   end

endmodule

// File: tb/tb_tap_classifier.sv
// Self-checking bench for tap_classifier with a window of 8 cycles.
// Expected outputs come from a gesture-grouping model built from press times.
module tb_tap_classifier;

   localparam int W    = 8;
   localparam int MAXN = 128;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn_pulse;
   logic       clear;
   logic       evt_valid;
   logic [1:0] evt_taps;
   logic       single_tap;
   logic       double_tap;
   logic       triple_tap;
   logic       busy;

   int checks = 0;
   int errors = 0;

   bit         pulse_s [0:MAXN-1];
   bit         clear_s [0:MAXN-1];
   logic [6:0] exp_vec [0:MAXN-1];

   tap_classifier #(.WINDOW_CYCLES(W), .TMR_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_pulse  (btn_pulse),
      .clear      (clear),
      .evt_valid  (evt_valid),
      .evt_taps   (evt_taps),
      .single_tap (single_tap),
      .double_tap (double_tap),
      .triple_tap (triple_tap),
      .busy       (busy)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Packed view of all outputs: {evt_valid, evt_taps, single, double, triple, busy}.
   function automatic logic [6:0] obs();
      return {evt_valid, evt_taps, single_tap, double_tap, triple_tap, busy};
   endfunction

   task automatic clear_sched();
      for (int i = 0; i < MAXN; i++) begin
         pulse_s[i] = 1'b0;
         clear_s[i] = 1'b0;
      end
   endtask

   // Reference: walk the press times, grouping presses no more than W edges apart
   // into one gesture of at most three taps; clear abandons an open gesture.
   task automatic build_model(input int n);
      bit open;
      int last;
      int count;
      bit ev;
      int ev_taps;
      open = 1'b0;
      last = 0;
      count = 0;
      for (int t = 0; t < n; t++) begin
         ev = 1'b0;
         ev_taps = 0;
         if (open) begin
            if (clear_s[t]) begin
               open = 1'b0;
            end else if (pulse_s[t] && (t - last) <= W) begin
               count++;
               last = t;
               if (count == 3) begin
                  ev = 1'b1;
                  ev_taps = 3;
                  open = 1'b0;
               end
            end else if ((t - last) == W) begin
               ev = 1'b1;
               ev_taps = count;
               open = 1'b0;
            end
         end else if (pulse_s[t]) begin
            open = 1'b1;
            last = t;
            count = 1;
         end
         exp_vec[t] = {ev, 2'(ev_taps), ev && ev_taps == 1, ev && ev_taps == 2,
                       ev && ev_taps == 3, open};
      end
   endtask

   // Apply the inputs for edge t, then wait until just after that edge.
   task automatic drive_edge(input int t);
      @(negedge clk);
      btn_pulse = pulse_s[t];
      clear     = clear_s[t];
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      btn_pulse = 1'b0;
      clear = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (obs() !== 7'b0) begin
         errors++;
         $display("[TB] FAIL reset_state: got %b expected %b", obs(), 7'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      // Build up a two-tap gesture, then pull reset asynchronously mid-cycle.
      clear_sched();
      pulse_s[1] = 1'b1;
      pulse_s[3] = 1'b1;
      build_model(6);
      for (int t = 0; t < 6; t++) begin
         drive_edge(t);
         checks++;
         if (obs() !== exp_vec[t]) begin
            errors++;
            $display("[TB] FAIL reset_pre edge %0d: got %b expected %b", t, obs(), exp_vec[t]);
         end
      end
      btn_pulse = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs() !== 7'b0) begin
         errors++;
         $display("[TB] FAIL reset_async: got %b expected %b", obs(), 7'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      clear_sched();
      build_model(16);
      for (int t = 0; t < 16; t++) begin
         drive_edge(t);
         checks++;
         if (obs() !== exp_vec[t]) begin
            errors++;
            $display("[TB] FAIL reset_after edge %0d: got %b expected %b", t, obs(), exp_vec[t]);
         end
      end
   endtask

   task automatic test_single();
      clear_sched();
      pulse_s[2] = 1'b1;
      build_model(16);
      for (int t = 0; t < 16; t++) begin
         drive_edge(t);
         checks++;
         if (obs() !== exp_vec[t]) begin
            errors++;
            $display("[TB] FAIL single edge %0d: got %b expected %b", t, obs(), exp_vec[t]);
         end
      end
   endtask

   task automatic test_double();
      clear_sched();
      pulse_s[2] = 1'b1;
      pulse_s[7] = 1'b1;
      build_model(24);
      for (int t = 0; t < 24; t++) begin
         drive_edge(t);
         checks++;
         if (obs() !== exp_vec[t]) begin
            errors++;
            $display("[TB] FAIL double edge %0d: got %b expected %b", t, obs(), exp_vec[t]);
         end
      end
   endtask

   task automatic test_triple();
      clear_sched();
      pulse_s[2] = 1'b1;
      pulse_s[5] = 1'b1;
      pulse_s[8] = 1'b1;
      build_model(24);
      for (int t = 0; t < 24; t++) begin
         drive_edge(t);
         checks++;
         if (obs() !== exp_vec[t]) begin
            errors++;
            $display("[TB] FAIL triple edge %0d: got %b expected %b", t, obs(), exp_vec[t]);
         end
      end
   endtask

   task automatic test_window();
      // Second press exactly W edges later still joins the gesture.
      clear_sched();
      pulse_s[2]  = 1'b1;
      pulse_s[10] = 1'b1;
      build_model(28);
      for (int t = 0; t < 28; t++) begin
         drive_edge(t);
         checks++;
         if (obs() !== exp_vec[t]) begin
            errors++;
            $display("[TB] FAIL window_in edge %0d: got %b expected %b", t, obs(), exp_vec[t]);
         end
      end
      // One edge later it lands in the strobe cycle and starts a new gesture.
      clear_sched();
      pulse_s[2]  = 1'b1;
      pulse_s[11] = 1'b1;
      build_model(32);
      for (int t = 0; t < 32; t++) begin
         drive_edge(t);
         checks++;
         if (obs() !== exp_vec[t]) begin
            errors++;
            $display("[TB] FAIL window_out edge %0d: got %b expected %b", t, obs(), exp_vec[t]);
         end
      end
   endtask

   task automatic test_clear();
      clear_sched();
      clear_s[1]  = 1'b1;
      pulse_s[2]  = 1'b1;
      clear_s[6]  = 1'b1;
      pulse_s[20] = 1'b1;
      pulse_s[22] = 1'b1;
      clear_s[22] = 1'b1;
      build_model(40);
      for (int t = 0; t < 40; t++) begin
         drive_edge(t);
         checks++;
         if (obs() !== exp_vec[t]) begin
            errors++;
            $display("[TB] FAIL clear edge %0d: got %b expected %b", t, obs(), exp_vec[t]);
         end
      end
   endtask

   task automatic test_back_to_back();
      clear_sched();
      pulse_s[2] = 1'b1;
      pulse_s[4] = 1'b1;
      pulse_s[6] = 1'b1;
      pulse_s[7] = 1'b1;
      build_model(24);
      for (int t = 0; t < 24; t++) begin
         drive_edge(t);
         checks++;
         if (obs() !== exp_vec[t]) begin
            errors++;
            $display("[TB] FAIL back_to_back edge %0d: got %b expected %b", t, obs(), exp_vec[t]);
         end
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         clear_sched();
         for (int t = 0; t < 100; t++) begin
            pulse_s[t] = ($urandom_range(0, 3) == 0);
            clear_s[t] = ($urandom_range(0, 15) == 0);
         end
         build_model(112);
         for (int t = 0; t < 112; t++) begin
            drive_edge(t);
            checks++;
            if (obs() !== exp_vec[t]) begin
               errors++;
               $display("[TB] FAIL random round %0d edge %0d: got %b expected %b",
                        r, t, obs(), exp_vec[t]);
            end
         end
      end
   endtask

   // Run every scenario in sequence; each leaves the DUT idle for the next.
   initial begin
      test_reset();
      test_single();
      test_double();
      test_triple();
      test_window();
      test_clear();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
